// File: rtl/data_bus_arbiter_if.sv
// rtl/data_bus_arbiter_if.sv - bundled master-side and slave-side signals of the data bus arbiter
interface data_bus_arbiter_if;
    logic        iM0ReadEnable;
    logic        iM0WriteEnable;
    logic [3:0]  iM0ByteEnable;
    logic [31:0] iM0Address;
    logic [31:0] iM0WriteData;
    logic [31:0] oM0ReadData;
    logic        oM0Ready;
    logic        oM0Error;

    logic        iM1ReadEnable;
    logic        iM1WriteEnable;
    logic [3:0]  iM1ByteEnable;
    logic [31:0] iM1Address;
    logic [31:0] iM1WriteData;
    logic [31:0] oM1ReadData;
    logic        oM1Ready;
    logic        oM1Error;

    logic        oDwReadEnable;
    logic        oDwWriteEnable;
    logic [3:0]  oDwByteEnable;
    logic [31:0] oDwAddress;
    logic [31:0] oDwWriteData;
    logic [31:0] iDwReadData;
    logic        iAck;

    logic [1:0]  oGrant;

    // Arbiter view: takes requests and slave responses, drives completions and slave strobes
    modport slave (
        input  iM0ReadEnable, iM0WriteEnable, iM0ByteEnable, iM0Address, iM0WriteData,
        input  iM1ReadEnable, iM1WriteEnable, iM1ByteEnable, iM1Address, iM1WriteData,
        input  iDwReadData, iAck,
        output oM0ReadData, oM0Ready, oM0Error,
        output oM1ReadData, oM1Ready, oM1Error,
        output oDwReadEnable, oDwWriteEnable, oDwByteEnable, oDwAddress, oDwWriteData,
        output oGrant
    );

    // Environment view: the masters and the memory around the arbiter
    modport master (
        output iM0ReadEnable, iM0WriteEnable, iM0ByteEnable, iM0Address, iM0WriteData,
        output iM1ReadEnable, iM1WriteEnable, iM1ByteEnable, iM1Address, iM1WriteData,
        output iDwReadData, iAck,
        input  oM0ReadData, oM0Ready, oM0Error,
        input  oM1ReadData, oM1Ready, oM1Error,
        input  oDwReadEnable, oDwWriteEnable, oDwByteEnable, oDwAddress, oDwWriteData,
        input  oGrant
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master round-robin data bus arbiter with ack watchdog
// All outputs are registered; the FSM serializes one transaction at a time:
// IDLE grants, BUSY waits for iAck or timeout, DONE carries the one-cycle ready pulse.
module data_bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    data_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      stateNext;
    logic [7:0]  count;
    logic        lastGrant;      // 1: M1 was granted last, so M0 wins the next tie
    logic        m0Req;
    logic        m1Req;
    logic        grantM0;
    logic        grantM1;
    logic        finishAck;
    logic        finishTimeout;
    logic [31:0] ackData;

    assign m0Req = bus.iM0ReadEnable | bus.iM0WriteEnable;
    assign m1Req = bus.iM1ReadEnable | bus.iM1WriteEnable;

    // State register
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and arbitration decisions
    always_comb begin
        stateNext     = state;
        grantM0       = 1'b0;
        grantM1       = 1'b0;
        finishAck     = 1'b0;
        finishTimeout = 1'b0;
        // Writes (including both enables set) return zero read data
        ackData       = bus.oDwWriteEnable ? 32'h0 : bus.iDwReadData;
        case (state)
            IDLE: begin
                if (m0Req && m1Req) begin
                    grantM0 = lastGrant;
                    grantM1 = ~lastGrant;
                end else begin
                    grantM0 = m0Req;
                    grantM1 = m1Req;
                end
                if (m0Req || m1Req) begin
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (bus.iAck) begin
                    finishAck = 1'b1;
                    stateNext = DONE;
                end else if (count == 8'(TIMEOUT - 1)) begin
                    finishTimeout = 1'b1;
                    stateNext     = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Registered bus copy, completion outputs, watchdog counter and fairness pointer
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            count              <= 8'd0;
            lastGrant          <= 1'b1;
            bus.oDwReadEnable  <= 1'b0;
            bus.oDwWriteEnable <= 1'b0;
            bus.oDwByteEnable  <= 4'd0;
            bus.oDwAddress     <= 32'd0;
            bus.oDwWriteData   <= 32'd0;
            bus.oGrant         <= 2'b00;
            bus.oM0Ready       <= 1'b0;
            bus.oM1Ready       <= 1'b0;
            bus.oM0Error       <= 1'b0;
            bus.oM1Error       <= 1'b0;
            bus.oM0ReadData    <= 32'd0;
            bus.oM1ReadData    <= 32'd0;
        end else begin
            if (grantM0) begin
                bus.oDwReadEnable  <= bus.iM0ReadEnable & ~bus.iM0WriteEnable;
                bus.oDwWriteEnable <= bus.iM0WriteEnable;
                bus.oDwByteEnable  <= bus.iM0ByteEnable;
                bus.oDwAddress     <= bus.iM0Address;
                bus.oDwWriteData   <= bus.iM0WriteData;
                bus.oGrant         <= 2'b01;
                lastGrant          <= 1'b0;
            end
            if (grantM1) begin
                bus.oDwReadEnable  <= bus.iM1ReadEnable & ~bus.iM1WriteEnable;
                bus.oDwWriteEnable <= bus.iM1WriteEnable;
                bus.oDwByteEnable  <= bus.iM1ByteEnable;
                bus.oDwAddress     <= bus.iM1Address;
                bus.oDwWriteData   <= bus.iM1WriteData;
                bus.oGrant         <= 2'b10;
                lastGrant          <= 1'b1;
            end
            if (state == BUSY) begin
                count <= count + 8'd1;
            end
            if (finishAck || finishTimeout) begin
                bus.oDwReadEnable  <= 1'b0;
                bus.oDwWriteEnable <= 1'b0;
                if (bus.oGrant[1]) begin
                    bus.oM1Ready    <= 1'b1;
                    bus.oM1Error    <= finishTimeout;
                    bus.oM1ReadData <= finishAck ? ackData : 32'h0;
                end else begin
                    bus.oM0Ready    <= 1'b1;
                    bus.oM0Error    <= finishTimeout;
                    bus.oM0ReadData <= finishAck ? ackData : 32'h0;
                end
            end
            if (state == DONE) begin
                bus.oM0Ready <= 1'b0;
                bus.oM1Ready <= 1'b0;
                bus.oM0Error <= 1'b0;
                bus.oM1Error <= 1'b0;
                bus.oGrant   <= 2'b00;
                count        <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - directed scoreboard bench for data_bus_arbiter
module tb_data_bus_arbiter;

    localparam logic [31:0] MASK = 32'h5A5A_5A5A;
    localparam logic [31:0] A0   = 32'h0000_1000;
    localparam logic [31:0] A1   = 32'h0000_2000;

    typedef struct {
        logic        m;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        useModel;
    logic [31:0] slaveData;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    data_bus_arbiter_if bus();

    data_bus_arbiter #(.TIMEOUT(4)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory model: either a fixed word or an address-derived word
    assign bus.iDwReadData = useModel ? (bus.oDwAddress ^ MASK) : slaveData;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input logic m, input logic [31:0] data, input logic err);
        exp_t e;
        e.m    = m;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic checkReady(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=ready expected=no_pending_transaction", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_m0rdy"}, bus.oM0Ready, 32'(!e.m));
            chk({tag, "_m1rdy"}, bus.oM1Ready, 32'(e.m));
            chk({tag, "_data"}, e.m ? bus.oM1ReadData : bus.oM0ReadData, e.data);
            chk({tag, "_err"}, e.m ? bus.oM1Error : bus.oM0Error, 32'(e.err));
        end
    endtask

    task automatic setM0(input logic re, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.iM0ReadEnable  = re;
        bus.iM0WriteEnable = we;
        bus.iM0ByteEnable  = be;
        bus.iM0Address     = addr;
        bus.iM0WriteData   = wd;
    endtask

    task automatic setM1(input logic re, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.iM1ReadEnable  = re;
        bus.iM1WriteEnable = we;
        bus.iM1ByteEnable  = be;
        bus.iM1Address     = addr;
        bus.iM1WriteData   = wd;
    endtask

    initial begin
        rst       = 1'b0;
        useModel  = 1'b1;
        slaveData = 32'h0;
        bus.iAck  = 1'b0;
        setM0(1'b1, 1'b0, 4'hF, A0, 32'h0);
        setM1(1'b1, 1'b0, 4'hF, A1, 32'h0);

        // Reset held two cycles with both masters requesting
        tick;
        tick;
        chk("rst_re",    bus.oDwReadEnable, 0);
        chk("rst_we",    bus.oDwWriteEnable, 0);
        chk("rst_be",    bus.oDwByteEnable, 0);
        chk("rst_addr",  bus.oDwAddress, 0);
        chk("rst_wd",    bus.oDwWriteData, 0);
        chk("rst_grant", bus.oGrant, 0);
        chk("rst_rdy",   {bus.oM1Ready, bus.oM0Ready}, 0);
        chk("rst_err",   {bus.oM1Error, bus.oM0Error}, 0);
        chk("rst_rd0",   bus.oM0ReadData, 0);
        chk("rst_rd1",   bus.oM1ReadData, 0);
        rst = 1'b1;
        tick;

        // Contention with immediate acks: M0, M1, M0, M1, each ready 3 cycles apart
        bus.iAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic m;
            m = i[0];
            chk("cont_grant", bus.oGrant, m ? 32'd2 : 32'd1);
            chk("cont_addr", bus.oDwAddress, m ? A1 : A0);
            pushExp(m, (m ? A1 : A0) ^ MASK, 1'b0);
            tick;
            checkReady("cont");
            tick;
            chk("cont_rdy_low", {bus.oM1Ready, bus.oM0Ready}, 0);
            if (i == 3) begin
                setM0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                bus.iAck = 1'b0;
            end
            tick;
        end
        chk("idle_grant", bus.oGrant, 0);

        // Single read from M0, ack after three BUSY cycles
        useModel  = 1'b0;
        slaveData = 32'hCAFE_F00D;
        setM0(1'b1, 1'b0, 4'hF, 32'h1001_0004, 32'h0);
        pushExp(1'b0, 32'hCAFE_F00D, 1'b0);
        tick;
        chk("rd_grant", bus.oGrant, 1);
        chk("rd_re",    bus.oDwReadEnable, 1);
        chk("rd_addr",  bus.oDwAddress, 32'h1001_0004);
        tick;
        tick;
        chk("rd_re_busy3", bus.oDwReadEnable, 1);
        bus.iAck = 1'b1;
        tick;
        checkReady("rd");
        chk("rd_re_done", bus.oDwReadEnable, 0);
        setM0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.iAck = 1'b0;
        tick;
        chk("rd_rdy_low", {bus.oM1Ready, bus.oM0Ready}, 0);
        chk("rd_hold",    bus.oM0ReadData, 32'hCAFE_F00D);
        chk("rd_grant0",  bus.oGrant, 0);

        // M1 with both enables set behaves as a write and returns zero
        slaveData = 32'hDEAD_BEEF;
        setM1(1'b1, 1'b1, 4'b0011, 32'h2000_0040, 32'h1234_5678);
        pushExp(1'b1, 32'h0, 1'b0);
        tick;
        chk("wr_we",    bus.oDwWriteEnable, 1);
        chk("wr_re",    bus.oDwReadEnable, 0);
        chk("wr_be",    bus.oDwByteEnable, 32'h3);
        chk("wr_wd",    bus.oDwWriteData, 32'h1234_5678);
        chk("wr_grant", bus.oGrant, 2);
        bus.iAck = 1'b1;
        tick;
        checkReady("wr");
        setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.iAck = 1'b0;
        tick;

        // Timeout: strobes high for four cycles, then ready+error; late ack ignored
        setM0(1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'h0);
        pushExp(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("to_re_busy", bus.oDwReadEnable, 1);
        end
        tick;
        checkReady("to");
        chk("to_re_done", bus.oDwReadEnable, 0);
        setM0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.iAck = 1'b1;
        tick;
        chk("to_late_rdy", {bus.oM1Ready, bus.oM0Ready}, 0);
        chk("to_late_err", bus.oM0Error, 0);
        bus.iAck = 1'b0;
        tick;
        chk("to_late_rdy2", {bus.oM1Ready, bus.oM0Ready}, 0);

        // Reset in the second BUSY cycle drops the access and restores M0 tie priority
        setM0(1'b1, 1'b0, 4'hF, 32'h4000_0000, 32'h0);
        tick;
        chk("mr_re_busy1", bus.oDwReadEnable, 1);
        tick;
        rst = 1'b0;
        tick;
        chk("mr_re",    bus.oDwReadEnable, 0);
        chk("mr_grant", bus.oGrant, 0);
        chk("mr_rdy",   {bus.oM1Ready, bus.oM0Ready}, 0);
        rst = 1'b1;
        setM1(1'b1, 1'b0, 4'hF, 32'h5000_0000, 32'h0);
        slaveData = 32'h0BAD_C0DE;
        tick;
        chk("mr_tie_grant", bus.oGrant, 1);
        pushExp(1'b0, 32'h0BAD_C0DE, 1'b0);
        bus.iAck = 1'b1;
        tick;
        checkReady("mr");
        setM0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setM1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.iAck = 1'b0;
        tick;
        tick;
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
